ama_riscv_ctrl_unit: RTL
========================

# ama_riscv_ctrl_unit

Parametrised successor to the pipeline instruction decoder. It decodes the ID-stage instruction into datapath controls and resolves branches and jumps in EX. It drives the per-stage clears and PC selection for the 5-stage core (IF/ID/EX/MEM/WB). Compared with the current decoder it adds:
- selectable branch handling: legacy stall-on-control, or predict-not-taken with flush
- NOP-forcing of squashed and illegal instructions, with a sticky illegal flag
- a saturating flush counter

## Interface
- `BR_MODE`, default 1: 0 = stall IF on every branch/jump in ID; 1 = predict-not-taken, flush on taken branch or jump.
- `FLUSH_CNT_W`, default 16: width of the flush counter.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `inst_id` input 32: instruction in ID.
- `inst_ex` input 32: instruction in EX (funct3 used for branch resolution).
- `bc_a_eq_b`, `bc_a_lt_b` input 1 each: branch-compare results for the EX operands.
- `stall_if`, `clear_if`, `clear_id`, `clear_ex`, `clear_mem` output 1 each: pipeline stall and clears.
- `pc_sel` output 2: next-PC mux select (INC4 / ALU / START_ADDR).
- `pc_we` output 1: PC write enable.
- Control outputs, same meaning and encodings as the existing decoder:
  - `store_inst`, `branch_inst`, `jump_inst`: output 1 each
  - `alu_op_sel`: output 4
  - `alu_a_sel`, `alu_b_sel`: output 1 each
  - `ig_sel`: output 3
  - `bc_uns`: output 1
  - `dmem_en`, `load_sm_en`: output 1 each
  - `wb_sel`: output 2
  - `reg_we`: output 1
- `illegal_inst` output 1: sticky; set on an unrecognised opcode in a live ID slot.
- `flush_cnt` output `FLUSH_CNT_W`: number of EX redirects, saturating.

## Operation
- **Decode per opcode**
  - R, I, LOAD, STORE, BRANCH, JALR, JAL, LUI and AUIPC produce the same control values as the current decoder.
  - Don't-care fields are driven to the NOP value below, not held from the previous cycle. There is no previous-value storage.
- **NOP value**
  - reg_we, dmem_en, store_inst, branch_inst, jump_inst, load_sm_en are 0.
  - alu_op_sel=ADD, alu_a_sel=RS1, alu_b_sel=RS2, ig_sel=DISABLED, bc_uns=0, wb_sel=ALU.
- **Live ID slot:** `!clear_id && !flow_change`. When the slot is not live, all control outputs are the NOP value.
- **Illegal opcode in a live slot:** controls are the NOP value and `illegal_inst` is set on the next edge. It stays set until `rst`.
- **EX tracking registers:** `branch_ex` and `jump_ex` register the (masked) `branch_inst`/`jump_inst` each cycle; reset to 0.
- **Branch resolution:** `br_res` is selected by `{funct3_ex[2],funct3_ex[0]}`:
  - BEQ: eq
  - BNE: !eq
  - BLT/BLTU: lt
  - BGE/BGEU: eq | !lt
- **Flow change:** `flow_change = (branch_ex & br_res) | jump_ex`, combinational.
- **PC control**
  - `pc_sel` priority: START_ADDR when `rst_pc` is set; else ALU when `flow_change`; else INC4.
  - `pc_we = !stall_if`.
- **BR_MODE=0**
  - `stall_if = branch_inst | jump_inst`.
  - `clear_if` = 0.
- **BR_MODE=1**
  - `stall_if` = 0.
  - On `flow_change`: `clear_if` = 1 and `clear_id` is forced to 1, squashing the two wrong-path instructions.
- **Reset sequence:** 3-bit shift register, loaded to 111 during `rst` and shifting in 0.
  - `clear_id = seq[0] | (BR_MODE & flow_change)`
  - `clear_ex = seq[1]`
  - `clear_mem = seq[2]`
- **`rst_pc` flag:** 1 during `rst` and for the first cycle after deassertion, then 0.
- **Flush counter:** increments on each cycle with `flow_change` and `!rst`. It saturates at all-ones and resets to 0.

## Timing
- **Reset values (during `rst` and the first cycle after):**
  - stall_if=0 and pc_we=1 (no ID-derived branch/jump while `clear_id` masks ID, in either mode)
  - clear_id/ex/mem=1; clear_if=0
  - pc_sel=START_ADDR
  - controls = NOP value
  - illegal_inst=0, flush_cnt=0
- **Clear release after `rst` deasserts:** clear_id drops after 1 cycle, clear_ex after 2, clear_mem after 3.
- **Latency:** decode is 0-cycle combinational from `inst_id`. Redirect happens in the EX cycle, one cycle after the branch or jump was in ID.
- **Taken-branch penalty:** 2 cycles in both modes. In mode 0 these are stall cycles; in mode 1 they are flushed slots.
  - Not-taken branch in mode 1: 0 cycles.
  - Not-taken branch in mode 0: 1 stall cycle.
- **Control in ID during a flow change:** it is squashed and never reaches `branch_ex`/`jump_ex`, so back-to-back branches cannot double-redirect.
- **`rst` mid-flush:** reset wins. The next cycle shows the reset values and flush_cnt=0.

## Structure
- Shared package (`ama_riscv_defines`) holds:
  - opcode constants (OPC7_*)
  - PC_SEL_*, ALU_*, ALU_A/B_SEL_*, IG_*, WB_SEL_*, BR_SEL_* constants
  - the NOP control bundle
- One sub-module: `ama_riscv_br_resolve`, taking funct3_ex, eq and lt and returning `br_res`.

## Test plan
- **Reset release:** hold rst 3 cycles, release, inst_id=0x00000013 (NOP) → cycle 0 pc_sel=START_ADDR; clears drop at +1/+2/+3; then pc_sel=INC4, pc_we=1.
- **Taken branch, mode 1:** inst_id=0x00208463 (beq x1,x2,8); next cycle eq=1 → flow_change, pc_sel=ALU, clear_if=clear_id=1; ID controls NOP; flush_cnt=1.
- **Not-taken branch, mode 1:** same beq with eq=0 → no clears; pc_sel=INC4; flush_cnt unchanged.
- **BR_MODE=0, jal x1,16 (0x010000EF) in ID:** stall_if=1, pc_we=0 in ID cycle; next cycle pc_sel=ALU, pc_we=1.
- **Illegal opcode 0xFFFFFFFF in a live slot:** reg_we=0, dmem_en=0; illegal_inst=1 next cycle and still 1 ten cycles later; cleared by rst.
- **Saturation:** with FLUSH_CNT_W=2, drive 5 jumps → flush_cnt=3.

Source files
------------

// File: rtl/ama_riscv_ctrl_unit_pkg.sv
// Shared decode constants and the control bundle for the ama_riscv pipeline control unit.
package ama_riscv_defines;

    localparam logic [6:0] OPC7_R_TYPE = 7'b011_0011;
    localparam logic [6:0] OPC7_I_TYPE = 7'b001_0011;
    localparam logic [6:0] OPC7_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC7_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC7_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC7_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC7_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC7_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC7_AUIPC  = 7'b001_0111;

    localparam logic [1:0] PC_SEL_INC4       = 2'd0;
    localparam logic [1:0] PC_SEL_ALU        = 2'd1;
    localparam logic [1:0] PC_SEL_START_ADDR = 2'd3;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic ALU_A_SEL_RS1 = 1'b0;
    localparam logic ALU_A_SEL_PC  = 1'b1;
    localparam logic ALU_B_SEL_RS2 = 1'b0;
    localparam logic ALU_B_SEL_IMM = 1'b1;

    localparam logic [2:0] IG_DISABLED = 3'd0;
    localparam logic [2:0] IG_I_TYPE   = 3'd1;
    localparam logic [2:0] IG_S_TYPE   = 3'd2;
    localparam logic [2:0] IG_B_TYPE   = 3'd3;
    localparam logic [2:0] IG_J_TYPE   = 3'd4;
    localparam logic [2:0] IG_U_TYPE   = 3'd5;

    localparam logic [1:0] WB_SEL_DMEM = 2'd0;
    localparam logic [1:0] WB_SEL_ALU  = 2'd1;
    localparam logic [1:0] WB_SEL_INC4 = 2'd2;

    localparam logic [1:0] BR_SEL_BEQ = 2'd0;
    localparam logic [1:0] BR_SEL_BNE = 2'd1;
    localparam logic [1:0] BR_SEL_BLT = 2'd2;
    localparam logic [1:0] BR_SEL_BGE = 2'd3;

    typedef struct packed {
        logic       store_inst;
        logic       branch_inst;
        logic       jump_inst;
        logic [3:0] alu_op_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [2:0] ig_sel;
        logic       bc_uns;
        logic       dmem_en;
        logic       load_sm_en;
        logic [1:0] wb_sel;
        logic       reg_we;
    } ctrl_t;

    // Bubble: no architectural side effects, benign datapath selects
    localparam ctrl_t CTRL_NOP = '{
        store_inst:  1'b0,
        branch_inst: 1'b0,
        jump_inst:   1'b0,
        alu_op_sel:  ALU_ADD,
        alu_a_sel:   ALU_A_SEL_RS1,
        alu_b_sel:   ALU_B_SEL_RS2,
        ig_sel:      IG_DISABLED,
        bc_uns:      1'b0,
        dmem_en:     1'b0,
        load_sm_en:  1'b0,
        wb_sel:      WB_SEL_ALU,
        reg_we:      1'b0
    };

endpackage

// File: rtl/ama_riscv_ctrl_unit_br_resolve.sv
// EX-stage branch condition: picks the compare outcome selected by funct3.
module ama_riscv_br_resolve
    import ama_riscv_defines::*;
(
    input  logic [2:0] funct3_ex,
    input  logic       eq,
    input  logic       lt,
    output logic       br_res
);

    logic [1:0] br_sel;
    logic       unused_f3;

    // funct3[1] only distinguishes signedness, already folded into lt
    assign br_sel    = {funct3_ex[2], funct3_ex[0]};
    assign unused_f3 = funct3_ex[1];

    always_comb begin
        br_res = 1'b0;
        case (br_sel)
            BR_SEL_BEQ: br_res = eq;
            BR_SEL_BNE: br_res = !eq;
            BR_SEL_BLT: br_res = lt;
            BR_SEL_BGE: br_res = eq | !lt;
            default:    br_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/ama_riscv_ctrl_unit.sv
// Pipeline control unit: ID decode, EX branch/jump redirect, stage clears, PC select,
// sticky illegal-opcode flag and a saturating redirect counter.
module ama_riscv_ctrl_unit
    import ama_riscv_defines::*;
#(
    parameter int unsigned BR_MODE     = 1,
    parameter int unsigned FLUSH_CNT_W = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            inst_id,
    input  logic [31:0]            inst_ex,
    input  logic                   bc_a_eq_b,
    input  logic                   bc_a_lt_b,
    output logic                   stall_if,
    output logic                   clear_if,
    output logic                   clear_id,
    output logic                   clear_ex,
    output logic                   clear_mem,
    output logic [1:0]             pc_sel,
    output logic                   pc_we,
    output logic                   store_inst,
    output logic                   branch_inst,
    output logic                   jump_inst,
    output logic [3:0]             alu_op_sel,
    output logic                   alu_a_sel,
    output logic                   alu_b_sel,
    output logic [2:0]             ig_sel,
    output logic                   bc_uns,
    output logic                   dmem_en,
    output logic                   load_sm_en,
    output logic [1:0]             wb_sel,
    output logic                   reg_we,
    output logic                   illegal_inst,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);

    localparam logic MODE_PNT = (BR_MODE != 32'd0);

    logic [2:0]             seq_q, seq_d;
    logic                   rst_pc_q, rst_pc_d;
    logic                   branch_ex_q, branch_ex_d;
    logic                   jump_ex_q, jump_ex_d;
    logic                   illegal_q, illegal_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic  br_res;
    logic  flow_change;
    logic  slot_live;
    logic  opc_legal;
    ctrl_t dec_c;
    ctrl_t ctrl_c;
    logic  unused_inst;

    assign unused_inst = ^{inst_ex[31:15], inst_ex[11:0], inst_id[31], inst_id[29:15], inst_id[11:7]};

    ama_riscv_br_resolve u_br_resolve (
        .funct3_ex (inst_ex[14:12]),
        .eq        (bc_a_eq_b),
        .lt        (bc_a_lt_b),
        .br_res    (br_res)
    );

    // Opcode decode; fields an opcode does not use stay at the bubble value
    always_comb begin
        dec_c     = CTRL_NOP;
        opc_legal = 1'b1;
        case (inst_id[6:0])
            OPC7_R_TYPE: begin
                dec_c.alu_op_sel = {inst_id[30], inst_id[14:12]};
                dec_c.reg_we     = 1'b1;
            end
            OPC7_I_TYPE: begin
                dec_c.alu_op_sel = (inst_id[14:12] == 3'b101) ? {inst_id[30], inst_id[14:12]}
                                                              : {1'b0, inst_id[14:12]};
                dec_c.alu_b_sel  = ALU_B_SEL_IMM;
                dec_c.ig_sel     = IG_I_TYPE;
                dec_c.reg_we     = 1'b1;
            end
            OPC7_LOAD: begin
                dec_c.alu_b_sel  = ALU_B_SEL_IMM;
                dec_c.ig_sel     = IG_I_TYPE;
                dec_c.dmem_en    = 1'b1;
                dec_c.load_sm_en = 1'b1;
                dec_c.wb_sel     = WB_SEL_DMEM;
                dec_c.reg_we     = 1'b1;
            end
            OPC7_STORE: begin
                dec_c.alu_b_sel  = ALU_B_SEL_IMM;
                dec_c.ig_sel     = IG_S_TYPE;
                dec_c.store_inst = 1'b1;
                dec_c.dmem_en    = 1'b1;
            end
            OPC7_BRANCH: begin
                dec_c.alu_a_sel   = ALU_A_SEL_PC;
                dec_c.alu_b_sel   = ALU_B_SEL_IMM;
                dec_c.ig_sel      = IG_B_TYPE;
                dec_c.branch_inst = 1'b1;
                dec_c.bc_uns      = inst_id[13];
            end
            OPC7_JALR: begin
                dec_c.alu_b_sel = ALU_B_SEL_IMM;
                dec_c.ig_sel    = IG_I_TYPE;
                dec_c.jump_inst = 1'b1;
                dec_c.wb_sel    = WB_SEL_INC4;
                dec_c.reg_we    = 1'b1;
            end
            OPC7_JAL: begin
                dec_c.alu_a_sel = ALU_A_SEL_PC;
                dec_c.alu_b_sel = ALU_B_SEL_IMM;
                dec_c.ig_sel    = IG_J_TYPE;
                dec_c.jump_inst = 1'b1;
                dec_c.wb_sel    = WB_SEL_INC4;
                dec_c.reg_we    = 1'b1;
            end
            OPC7_LUI: begin
                dec_c.alu_op_sel = ALU_PASS_B;
                dec_c.alu_b_sel  = ALU_B_SEL_IMM;
                dec_c.ig_sel     = IG_U_TYPE;
                dec_c.reg_we     = 1'b1;
            end
            OPC7_AUIPC: begin
                dec_c.alu_a_sel = ALU_A_SEL_PC;
                dec_c.alu_b_sel = ALU_B_SEL_IMM;
                dec_c.ig_sel    = IG_U_TYPE;
                dec_c.reg_we    = 1'b1;
            end
            default: opc_legal = 1'b0;
        endcase
    end

    assign flow_change = (branch_ex_q & br_res) | jump_ex_q;
    assign clear_id    = seq_q[0] | (MODE_PNT & flow_change);
    assign clear_ex    = seq_q[1];
    assign clear_mem   = seq_q[2];
    assign slot_live   = !clear_id && !flow_change;
    assign ctrl_c      = slot_live ? dec_c : CTRL_NOP;

    assign store_inst  = ctrl_c.store_inst;
    assign branch_inst = ctrl_c.branch_inst;
    assign jump_inst   = ctrl_c.jump_inst;
    assign alu_op_sel  = ctrl_c.alu_op_sel;
    assign alu_a_sel   = ctrl_c.alu_a_sel;
    assign alu_b_sel   = ctrl_c.alu_b_sel;
    assign ig_sel      = ctrl_c.ig_sel;
    assign bc_uns      = ctrl_c.bc_uns;
    assign dmem_en     = ctrl_c.dmem_en;
    assign load_sm_en  = ctrl_c.load_sm_en;
    assign wb_sel      = ctrl_c.wb_sel;
    assign reg_we      = ctrl_c.reg_we;

    // Stall mode holds IF until the control instruction resolves; PNT mode flushes instead
    assign stall_if = !MODE_PNT & (ctrl_c.branch_inst | ctrl_c.jump_inst);
    assign clear_if = MODE_PNT & flow_change;
    assign pc_we    = !stall_if;

    always_comb begin
        pc_sel = PC_SEL_INC4;
        if (rst_pc_q) begin
            pc_sel = PC_SEL_START_ADDR;
        end else if (flow_change) begin
            pc_sel = PC_SEL_ALU;
        end
    end

    assign illegal_inst = illegal_q;
    assign flush_cnt    = flush_cnt_q;

    always_comb begin
        seq_d       = {seq_q[1:0], 1'b0};
        rst_pc_d    = 1'b0;
        branch_ex_d = ctrl_c.branch_inst;
        jump_ex_d   = ctrl_c.jump_inst;
        illegal_d   = illegal_q | (slot_live & !opc_legal);
        flush_cnt_d = flush_cnt_q;
        if (flow_change && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q       <= 3'b111;
            rst_pc_q    <= 1'b1;
            branch_ex_q <= 1'b0;
            jump_ex_q   <= 1'b0;
            illegal_q   <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            seq_q       <= seq_d;
            rst_pc_q    <= rst_pc_d;
            branch_ex_q <= branch_ex_d;
            jump_ex_q   <= jump_ex_d;
            illegal_q   <= illegal_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
